// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the RV32 control pipeline.
// Holds the ctrl_t control word, opcode values, field encodings and the
// all-zero bubble word used for flushes and reset.
package ctrl_pkg;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // aluop encodings
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // resultsrc encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // wdsel encodings
  localparam logic [1:0] WD_RESULT = 2'b00;
  localparam logic [1:0] WD_LOAD   = 2'b01;
  localparam logic [1:0] WD_IMM    = 2'b10;
  localparam logic [1:0] WD_PC_IMM = 2'b11;

  // immsrc encodings
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_B = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Field order is MSB first: alusrc is bit 15, illegal is bit 0.
  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       regwrite;
    logic [2:0] immsrc;
    logic       memwrite;
    logic [1:0] wdsel;
    logic [1:0] resultsrc;
    logic       jumpsel;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // No register write, no memory write, no redirect.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
// Ports:
//   i_op_d   - opcode of the instruction in ID
//   o_ctrl_d - decoded control word; unknown opcodes give bubble + illegal
// JUMP_EN=0 turns jal/jalr into illegal instructions.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit JUMP_EN = 1'b1
) (
  input  logic [6:0] i_op_d,
  output ctrl_t      o_ctrl_d
);

  always_comb begin
    o_ctrl_d = CTRL_BUBBLE;
    case (i_op_d)
      OP_R: begin
        o_ctrl_d.aluop    = ALUOP_FUNCT;
        o_ctrl_d.regwrite = 1'b1;
      end
      OP_I: begin
        o_ctrl_d.alusrc   = 1'b1;
        o_ctrl_d.aluop    = ALUOP_FUNCT;
        o_ctrl_d.regwrite = 1'b1;
      end
      OP_LOAD: begin
        o_ctrl_d.alusrc    = 1'b1;
        o_ctrl_d.regwrite  = 1'b1;
        o_ctrl_d.wdsel     = WD_LOAD;
        o_ctrl_d.resultsrc = RES_MEM;
      end
      OP_STORE: begin
        o_ctrl_d.alusrc   = 1'b1;
        o_ctrl_d.immsrc   = IMM_S;
        o_ctrl_d.memwrite = 1'b1;
      end
      OP_LUI: begin
        o_ctrl_d.regwrite = 1'b1;
        o_ctrl_d.immsrc   = IMM_U;
        o_ctrl_d.wdsel    = WD_IMM;
      end
      OP_AUIPC: begin
        o_ctrl_d.regwrite = 1'b1;
        o_ctrl_d.immsrc   = IMM_U;
        o_ctrl_d.wdsel    = WD_PC_IMM;
      end
      OP_BRANCH: begin
        o_ctrl_d.aluop  = ALUOP_BRANCH;
        o_ctrl_d.immsrc = IMM_B;
        o_ctrl_d.branch = 1'b1;
      end
      OP_JAL: begin
        if (JUMP_EN) begin
          o_ctrl_d.regwrite  = 1'b1;
          o_ctrl_d.immsrc    = IMM_J;
          o_ctrl_d.resultsrc = RES_PC4;
          o_ctrl_d.jump      = 1'b1;
        end else begin
          o_ctrl_d.illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (JUMP_EN) begin
          o_ctrl_d.alusrc    = 1'b1;
          o_ctrl_d.regwrite  = 1'b1;
          o_ctrl_d.resultsrc = RES_PC4;
          o_ctrl_d.jumpsel   = 1'b1;
          o_ctrl_d.jump      = 1'b1;
        end else begin
          o_ctrl_d.illegal = 1'b1;
        end
      end
      default: o_ctrl_d.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-word pipeline (EX/MEM/WB) with hazard unit.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   op_d, rs1_d, rs2_d  - opcode and source registers of the ID instruction
//   rd_e, pcsrc_e       - destination register and redirect from EX
//   immsrc_d            - immediate format for ID (combinational)
//   ctrl_e/m/w          - registered control words for EX, MEM, WB
//   stall_f, stall_d    - hold PC and IF/ID
//   flush_d, flush_e    - clear IF/ID, insert bubble into EX
//   illegal_w           - pulse while an illegal instruction is in WB
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter bit          JUMP_EN = 1'b1,
  parameter bit          TRAP_EN = 1'b1,
  parameter int unsigned REG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              pcsrc_e,
  output logic [2:0]        immsrc_d,
  output ctrl_t             ctrl_e,
  output ctrl_t             ctrl_m,
  output ctrl_t             ctrl_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              illegal_w
);

  ctrl_t r_ctrl_e, r_ctrl_m, r_ctrl_w;
  ctrl_t w_ctrl_dec;
  logic  w_lduse;

  ctrl_decode #(
    .JUMP_EN (JUMP_EN)
  ) u_decode (
    .i_op_d   (op_d),
    .o_ctrl_d (w_ctrl_dec)
  );

  // A load in EX whose destination feeds the ID instruction; x0 never hazards.
  assign w_lduse = (r_ctrl_e.resultsrc == RES_MEM) && (rd_e != '0) &&
                   ((rd_e == rs1_d) || (rd_e == rs2_d));

  // A redirect wins over load-use: the dependent instruction is being discarded.
  assign flush_d = pcsrc_e;
  assign flush_e = pcsrc_e | w_lduse;
  assign stall_f = w_lduse & ~pcsrc_e;
  assign stall_d = w_lduse & ~pcsrc_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_e <= CTRL_BUBBLE;
      r_ctrl_m <= CTRL_BUBBLE;
      r_ctrl_w <= CTRL_BUBBLE;
    end else begin
      r_ctrl_e <= flush_e ? CTRL_BUBBLE : w_ctrl_dec;
      r_ctrl_m <= r_ctrl_e;
      r_ctrl_w <= r_ctrl_m;
    end
  end

  assign immsrc_d  = w_ctrl_dec.immsrc;
  assign ctrl_e    = r_ctrl_e;
  assign ctrl_m    = r_ctrl_m;
  assign ctrl_w    = r_ctrl_w;
  assign illegal_w = TRAP_EN & r_ctrl_w.illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe.
// Two instances: dut0 uses defaults, dut1 has JUMP_EN=0 and REG_AW=4.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_d;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       pcsrc_e;
  logic [3:0] rs1_n, rs2_n, rd_n;

  assign rs1_n = rs1_d[3:0];
  assign rs2_n = rs2_d[3:0];
  assign rd_n  = rd_e[3:0];

  logic [2:0] imm0, imm1;
  ctrl_t      e0, m0, w0, e1, m1, w1;
  logic       sf0, sd0, fd0, fe0, ill0;
  logic       sf1, sd1, fd1, fe1, ill1;

  always #5 clk = ~clk;

  ctrl_pipe dut0 (
    .clk (clk), .reset (reset), .op_d (op_d), .rs1_d (rs1_d), .rs2_d (rs2_d),
    .rd_e (rd_e), .pcsrc_e (pcsrc_e), .immsrc_d (imm0), .ctrl_e (e0), .ctrl_m (m0),
    .ctrl_w (w0), .stall_f (sf0), .stall_d (sd0), .flush_d (fd0), .flush_e (fe0),
    .illegal_w (ill0)
  );

  ctrl_pipe #(.JUMP_EN (1'b0), .TRAP_EN (1'b1), .REG_AW (4)) dut1 (
    .clk (clk), .reset (reset), .op_d (op_d), .rs1_d (rs1_n), .rs2_d (rs2_n),
    .rd_e (rd_n), .pcsrc_e (pcsrc_e), .immsrc_d (imm1), .ctrl_e (e1), .ctrl_m (m1),
    .ctrl_w (w1), .stall_f (sf1), .stall_d (sd1), .flush_d (fd1), .flush_e (fe1),
    .illegal_w (ill1)
  );

  // Observed values gathered per instance for looped checking
  logic [15:0] e_obs [2], m_obs [2], w_obs [2];
  logic [3:0]  haz_obs [2];
  logic [2:0]  imm_obs [2];
  logic        ill_obs [2];
  always_comb begin
    e_obs[0] = e0;  m_obs[0] = m0;  w_obs[0] = w0;
    e_obs[1] = e1;  m_obs[1] = m1;  w_obs[1] = w1;
    haz_obs[0] = {sf0, sd0, fd0, fe0};
    haz_obs[1] = {sf1, sd1, fd1, fe1};
    imm_obs[0] = imm0;  imm_obs[1] = imm1;
    ill_obs[0] = ill0;  ill_obs[1] = ill1;
  end

  int n_total = 0;
  int n_pass  = 0;

  // Expected pipeline contents per instance: [0]=EX, [1]=MEM, [2]=WB
  logic [15:0] mp [2][3];

  // Control words straight from the decode table, illegal flag appended as bit 0.
  function automatic logic [15:0] ref_decode(input logic [6:0] op, input bit jen);
    case (op)
      7'b0110011: return 16'b0_10_1_000_0_00_00_0_0_0_0;
      7'b0010011: return 16'b1_10_1_000_0_00_00_0_0_0_0;
      7'b0000011: return 16'b1_00_1_000_0_01_01_0_0_0_0;
      7'b0100011: return 16'b1_00_0_010_1_00_00_0_0_0_0;
      7'b0110111: return 16'b0_00_1_100_0_10_00_0_0_0_0;
      7'b0010111: return 16'b0_00_1_100_0_11_00_0_0_0_0;
      7'b1100011: return 16'b0_01_0_001_0_00_00_0_1_0_0;
      7'b1101111: return jen ? 16'b0_00_1_011_0_00_10_0_0_1_0 : 16'h0001;
      7'b1100111: return jen ? 16'b1_00_1_000_0_00_10_1_0_1_0 : 16'h0001;
      default:    return 16'h0001;
    endcase
  endfunction

  // Load-use: EX word's resultsrc field (bits 5:4) selects memory.
  function automatic bit ref_lduse(input logic [15:0] e, input logic [4:0] rd,
                                   input logic [4:0] r1, input logic [4:0] r2);
    return (e[5:4] == 2'b01) && (rd != 0) && ((rd == r1) || (rd == r2));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic cycle();
    logic [4:0]  rd [2], r1 [2], r2 [2];
    logic [15:0] dec [2];
    bit          ld [2];
    rd[0] = rd_e;               r1[0] = rs1_d;               r2[0] = rs2_d;
    rd[1] = {1'b0, rd_e[3:0]};  r1[1] = {1'b0, rs1_d[3:0]};  r2[1] = {1'b0, rs2_d[3:0]};
    for (int k = 0; k < 2; k++) begin
      dec[k] = ref_decode(op_d, k == 0);
      ld[k]  = ref_lduse(mp[k][0], rd[k], r1[k], r2[k]);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("immsrc%0d", k), 16'(imm_obs[k]), 16'(dec[k][11:9]));
      chk($sformatf("hazard%0d", k), 16'(haz_obs[k]),
          16'({ld[k] & ~pcsrc_e, ld[k] & ~pcsrc_e, pcsrc_e, pcsrc_e | ld[k]}));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mp[k][0] = '0; mp[k][1] = '0; mp[k][2] = '0;
      end else begin
        mp[k][2] = mp[k][1];
        mp[k][1] = mp[k][0];
        mp[k][0] = (pcsrc_e | ld[k]) ? 16'h0000 : dec[k];
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ctrl_e%0d", k), e_obs[k], mp[k][0]);
      chk($sformatf("ctrl_m%0d", k), m_obs[k], mp[k][1]);
      chk($sformatf("ctrl_w%0d", k), w_obs[k], mp[k][2]);
      chk($sformatf("illegal_w%0d", k), 16'(ill_obs[k]), 16'(mp[k][2][0]));
    end
  endtask

  logic [6:0] op_pool [11];

  initial begin
    op_pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000, 7'b1111111};
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 3; s++) mp[k][s] = 16'hxxxx;

    reset = 1'b1; op_d = 7'b0110011; rs1_d = 0; rs2_d = 0; rd_e = 0; pcsrc_e = 0;
    cycle();
    cycle();
    chk("reset_e", e_obs[0], 16'h0000);
    chk("reset_w", w_obs[1], 16'h0000);
    chk("reset_illegal_w", 16'(ill0), 16'h0000);
    reset = 1'b0;

    // R-type for three cycles reaches WB
    op_d = 7'b0110011;
    cycle(); cycle(); cycle();
    chk("r_wb_regwrite", 16'(w0.regwrite), 16'h0001);
    chk("r_wb_aluop", 16'(w0.aluop), 16'h0002);
    chk("r_wb_illegal_w", 16'(ill0), 16'h0000);

    // Load-use with rd_e=5
    op_d = 7'b0000011;
    cycle();
    op_d = 7'b0110011; rd_e = 5; rs1_d = 5; rs2_d = 0;
    #1;
    chk("lduse_stall", 16'(haz_obs[0]), 16'b1101);
    chk("lduse_stall_aw4", 16'(haz_obs[1]), 16'b1101);
    cycle();
    chk("lduse_bubble", e_obs[0], 16'h0000);

    // Same with rd_e=0: x0 never hazards
    op_d = 7'b0000011; rd_e = 0; rs1_d = 0;
    cycle();
    op_d = 7'b0110011;
    #1;
    chk("lduse_x0", 16'(haz_obs[0]), 16'b0000);
    cycle();

    // Redirect together with load-use
    op_d = 7'b0000011;
    cycle();
    op_d = 7'b0110011; rd_e = 5; rs1_d = 5; pcsrc_e = 1;
    #1;
    chk("redirect_over_lduse", 16'(haz_obs[0]), 16'b0011);
    cycle();
    pcsrc_e = 0; rd_e = 0; rs1_d = 0;

    // jal: legal on dut0, illegal on dut1 with a single WB pulse
    op_d = 7'b1101111;
    cycle();
    chk("jal_jump", 16'(e0.jump), 16'h0001);
    chk("jal_resultsrc", 16'(e0.resultsrc), 16'h0002);
    chk("jal_illegal_nojump", 16'(e1.illegal), 16'h0001);
    op_d = 7'b0110011;
    cycle();
    chk("jal_pulse_early", 16'(ill1), 16'h0000);
    cycle();
    chk("jal_pulse", 16'(ill1), 16'h0001);
    cycle();
    chk("jal_pulse_end", 16'(ill1), 16'h0000);

    // Illegal opcode in ID while a redirect resolves never reaches WB
    op_d = 7'b0000000; pcsrc_e = 1;
    cycle();
    op_d = 7'b0110011; pcsrc_e = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flushed_illegal", 16'(ill0), 16'h0000);
    end

    // Reset while a store sits in MEM
    op_d = 7'b0100011;
    cycle();
    op_d = 7'b0110011;
    cycle();
    chk("store_in_mem0", 16'(m0.memwrite), 16'h0001);
    chk("store_in_mem1", 16'(m1.memwrite), 16'h0001);
    reset = 1;
    cycle();
    chk("reset_store0", 16'(m0.memwrite), 16'h0000);
    chk("reset_store1", 16'(m1.memwrite), 16'h0000);
    reset = 0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) op_d = 7'($urandom);
      else op_d = op_pool[$urandom_range(0, 10)];
      rs1_d   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      rs2_d   = 5'($urandom_range(0, 3));
      rd_e    = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      pcsrc_e = ($urandom_range(0, 4) == 0);
      reset   = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
